// File: rtl/dmem_bridge_pkg.sv
// Shared types for the dmem bridge: bus word/mask types, write-buffer entry,
// and drain FSM state encoding.
package dmem_bridge_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef struct packed {
    lc3b_word      addr;
    lc3b_word      data;
    lc3b_mem_wmask mask;
  } lc3b_wbuf_entry;

  typedef enum logic [1:0] {
    IDLE,
    WR_BUSY,
    RD_BUSY,
    RD_DONE
  } dmem_bridge_state_t;

  localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

  // Word-granular address compare (byte offset ignored).
  function automatic logic same_word(input lc3b_word a, input lc3b_word b);
    return a[15:1] == b[15:1];
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request bus (dmem_*) and physical memory handshake (pmem_*) of the bridge.
// slave: the bridge's view; master: the requester/memory side.
interface dmem_bridge_if;
  import dmem_bridge_pkg::*;

  logic          dmem_action_cyc;
  logic          dmem_action_stb;
  logic          dmem_write;
  lc3b_mem_wmask dmem_byte_enable;
  lc3b_word      dmem_address;
  lc3b_word      dmem_wdata;
  logic          dmem_resp;
  lc3b_word      dmem_data_out;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_mem_wmask pmem_wmask;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  dmem_action_cyc, dmem_action_stb, dmem_write, dmem_byte_enable,
           dmem_address, dmem_wdata, pmem_rdata, pmem_resp,
    output dmem_resp, dmem_data_out, pmem_read, pmem_write, pmem_address,
           pmem_wdata, pmem_wmask
  );

  modport master (
    output dmem_action_cyc, dmem_action_stb, dmem_write, dmem_byte_enable,
           dmem_address, dmem_wdata, pmem_rdata, pmem_resp,
    input  dmem_resp, dmem_data_out, pmem_read, pmem_write, pmem_address,
           pmem_wdata, pmem_wmask
  );

endinterface

// File: rtl/dmem_bridge_wbuf.sv
// dmem_wbuf: circular posted-write FIFO of lc3b_wbuf_entry.
// With DMEM_BRIDGE_FWD_EN defined it also exposes all entries in age order
// (index 0 = oldest) with a valid bit each, for store-to-load forwarding.
module dmem_wbuf
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  lc3b_wbuf_entry           push_entry,
  input  logic                     pop,
  output lc3b_wbuf_entry           head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef DMEM_BRIDGE_FWD_EN
  ,
  output lc3b_wbuf_entry [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]           valid
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);

  lc3b_wbuf_entry mem [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_entry;
  end

  assign head  = mem[head_ptr];
  assign full  = (count == DEPTH[PW:0]);
  assign empty = (count == '0);

`ifdef DMEM_BRIDGE_FWD_EN
  // Age-ordered view of the buffer for the forwarding comparators.
  always_comb begin
    entries = '0;
    valid   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries[k] = mem[head_ptr + PW'(k)];
      valid[k]   = (32'(count) > k);
    end
  end
`endif

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: dmem request bus to held-until-ack pmem handshake, with a
// posted-write buffer so stores retire in one cycle. Loads are ordered
// against buffered writes. Optional macro DMEM_BRIDGE_FWD_EN enables
// store-to-load forwarding from the write buffer.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_bridge_if.slave bus
);
  localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;

  dmem_bridge_state_t state, state_next;
  lc3b_wbuf_entry     head, push_entry;
  logic [CW-1:0]      wbuf_count;
  logic               full, empty, push, pop;
  logic               req, st_req, ld_req, ld_eligible, fwd;
  lc3b_word           fwd_data;

  // The requester keeps the request up during the dmem_resp cycle, so a
  // request seen while dmem_resp is high is the one already answered.
  assign req        = bus.dmem_action_cyc & bus.dmem_action_stb & ~bus.dmem_resp;
  assign st_req     = req & bus.dmem_write;
  assign ld_req     = req & ~bus.dmem_write;
  assign push       = st_req & ~full;
  assign pop        = (state == WR_BUSY) & bus.pmem_resp;
  assign push_entry = '{addr: bus.dmem_address, data: bus.dmem_wdata,
                        mask: bus.dmem_byte_enable};

`ifdef DMEM_BRIDGE_FWD_EN
  lc3b_wbuf_entry [WBUF_DEPTH-1:0] fwd_entries;
  logic [WBUF_DEPTH-1:0]           fwd_valid;
  logic                            hit, hit_full;

  dmem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk), .reset(reset), .push(push), .push_entry(push_entry), .pop(pop),
    .head(head), .count(wbuf_count), .full(full), .empty(empty),
    .entries(fwd_entries), .valid(fwd_valid)
  );

  // Newest matching entry wins: scan oldest to newest, last hit overrides.
  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
      if (fwd_valid[k] && same_word(fwd_entries[k].addr, bus.dmem_address)) begin
        hit      = 1'b1;
        hit_full = (fwd_entries[k].mask == WMASK_WORD);
        fwd_data = fwd_entries[k].data;
      end
    end
  end

  assign fwd         = ld_req & hit & hit_full &
                       ((state == IDLE) | (state == WR_BUSY));
  assign ld_eligible = ld_req & ((wbuf_count == '0) | ~hit);
`else
  dmem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk), .reset(reset), .push(push), .push_entry(push_entry), .pop(pop),
    .head(head), .count(wbuf_count), .full(full), .empty(empty)
  );

  assign fwd         = 1'b0;
  assign fwd_data    = '0;
  assign ld_eligible = ld_req & (wbuf_count == '0);
`endif

  // Drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Drain FSM next state: an eligible load beats a pending drain.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ld_eligible)  state_next = RD_BUSY;
        else if (!empty)  state_next = WR_BUSY;
      end
      WR_BUSY: if (bus.pmem_resp) state_next = IDLE;
      RD_BUSY: if (bus.pmem_resp) state_next = RD_DONE;
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered bus outputs; pmem fields are loaded on leaving IDLE and held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dmem_resp     <= 1'b0;
      bus.dmem_data_out <= '0;
      bus.pmem_read     <= 1'b0;
      bus.pmem_write    <= 1'b0;
      bus.pmem_address  <= '0;
      bus.pmem_wdata    <= '0;
      bus.pmem_wmask    <= '0;
    end else begin
      bus.dmem_resp <= push | fwd | ((state == RD_BUSY) & bus.pmem_resp);
      if (fwd)
        bus.dmem_data_out <= fwd_data;
      else if ((state == RD_BUSY) && bus.pmem_resp)
        bus.dmem_data_out <= bus.pmem_rdata;
      unique case (state)
        IDLE: begin
          if (ld_eligible) begin
            bus.pmem_read    <= 1'b1;
            bus.pmem_address <= bus.dmem_address;
            bus.pmem_wmask   <= WMASK_WORD;
          end else if (!empty) begin
            bus.pmem_write   <= 1'b1;
            bus.pmem_address <= head.addr;
            bus.pmem_wdata   <= head.data;
            bus.pmem_wmask   <= head.mask;
          end
        end
        WR_BUSY: if (bus.pmem_resp) bus.pmem_write <= 1'b0;
        RD_BUSY: if (bus.pmem_resp) bus.pmem_read  <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
